// File: rtl/mult_booth_seq_if.sv
// Operand/result handshake bundle between the control unit and the Booth multiplier.
// MULT_BOOTH_UNSIGNED_EN adds the is_unsigned request bit.
interface mult_booth_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
`ifdef MULT_BOOTH_UNSIGNED_EN
    logic             is_unsigned;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
`ifdef MULT_BOOTH_UNSIGNED_EN
        output is_unsigned,
`endif
        output start, op_a, op_b,
        input  busy, done, hi, lo
    );

    modport slave (
`ifdef MULT_BOOTH_UNSIGNED_EN
        input  is_unsigned,
`endif
        input  start, op_a, op_b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_booth_seq.sv
// Sequential radix-2 Booth multiplier, fixed latency, start/busy/done handshake.
// Optional MULT_BOOTH_UNSIGNED_EN adds an unsigned mode taking one extra step.
module mult_booth_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input logic             clk,
    input logic             reset,
    mult_booth_seq_if.slave bus
);

    localparam int unsigned AW = WIDTH + 1;
`ifdef MULT_BOOTH_UNSIGNED_EN
    localparam int unsigned QW = WIDTH + 1;
`else
    localparam int unsigned QW = WIDTH;
`endif
    localparam logic [CNT_W-1:0] LAST_S = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q;
    logic [AW-1:0]    m_q;
    logic [AW-1:0]    acc_q;
    logic [QW-1:0]    q_q;
    logic             q1_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
`ifdef MULT_BOOTH_UNSIGNED_EN
    logic             uns_q;
`endif

    logic [AW-1:0]    sum_c;
    logic [AW-1:0]    acc_d;
    logic [QW-1:0]    q_d;
    logic             q1_d;
    logic [WIDTH-1:0] hi_d;
    logic [WIDTH-1:0] lo_d;
    logic             last_c;

    // One Booth step: add/sub M, then arithmetic shift of {acc,Q,q_1}.
    always_comb begin
        sum_c = acc_q;
        case ({q_q[0], q1_q})
            2'b01:   sum_c = acc_q + m_q;
            2'b10:   sum_c = acc_q - m_q;
            default: sum_c = acc_q;
        endcase
        acc_d  = {sum_c[AW-1], sum_c[AW-1:1]};
        q_d    = {sum_c[0], q_q[QW-1:1]};
        q1_d   = q_q[0];
        hi_d   = acc_d[WIDTH-1:0];
        last_c = (cnt_q == LAST_S);
`ifdef MULT_BOOTH_UNSIGNED_EN
        // Signed runs leave the unused top Q bit in q_d[0]; unsigned runs one step further.
        lo_d = q_d[QW-1:1];
        if (uns_q) begin
            hi_d   = {acc_d[WIDTH-2:0], q_d[QW-1]};
            lo_d   = q_d[WIDTH-1:0];
            last_c = (cnt_q == CNT_W'(WIDTH));
        end
`else
        lo_d = q_d;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef MULT_BOOTH_UNSIGNED_EN
            uns_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
`ifdef MULT_BOOTH_UNSIGNED_EN
                        m_q   <= {(bus.is_unsigned ? 1'b0 : bus.op_a[WIDTH-1]), bus.op_a};
                        q_q   <= {1'b0, bus.op_b};
                        uns_q <= bus.is_unsigned;
`else
                        m_q   <= {bus.op_a[WIDTH-1], bus.op_a};
                        q_q   <= bus.op_b;
`endif
                        acc_q   <= '0;
                        q1_q    <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    q_q   <= q_d;
                    q1_q  <= q1_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_c) begin
                        hi_q    <= hi_d;
                        lo_q    <= lo_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: doc/mult_booth_seq.md
Name: mult_booth_seq

Overview:
- Sequential radix-2 Booth multiplier for the multicycle CPU's mult/multu path.
- Operands come from the A/B operand registers; the 64-bit product feeds the HI/LO registers through the div/mult select muxes.
- A start/busy/done handshake lets the control unit stall in a wait state until done.
- Replaces the free-running multiplier with a deterministic, fixed-latency unit.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH.
- CNT_W, 6, iteration counter width; must hold WIDTH+1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a multiply; sampled only in IDLE.
- op_a  in  WIDTH  multiplicand (A register).
- op_b  in  WIDTH  multiplier (B register).
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when hi/lo hold the new product.
- hi  out  WIDTH  product bits [2*WIDTH-1:WIDTH].
- lo  out  WIDTH  product bits [WIDTH-1:0].

Behaviour:
- Reset:
  - Asserted low, asynchronous, effective at any time including mid-operation.
  - state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, internal accumulator and shift registers cleared.
  - On release, the block waits for a fresh start; no partial result is ever committed.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - At a clk edge with start=1, capture operands: M <= sext(op_a) to WIDTH+1 bits; acc <= 0 (WIDTH+1 bits); Q <= op_b; q_1 <= 0; count <= 0.
  - Go to RUN. busy=1 from this edge.
- RUN, one Booth step per edge:
  - {Q[0],q_1}=01: acc+M. 10: acc-M. 00/11: no add.
  - Then arithmetic right shift of {acc,Q,q_1} by 1; acc MSB is replicated.
  - All arithmetic is WIDTH+1 bits wide, so op_a = -2^31 does not overflow.
  - count increments each step.
  - After the WIDTH-th step, on the same edge: hi <= acc[WIDTH-1:0] post-shift, lo <= Q post-shift. Go to DONE.
- DONE:
  - done=1, busy=0 for exactly one cycle. Next edge goes to IDLE unconditionally.
  - start is ignored in DONE.
- Latency: start sampled at edge N, steps at edges N+1..N+WIDTH. hi/lo and done are valid after edge N+WIDTH; 32 cycles for the default.
- start asserted while busy=1 or in DONE is ignored, with no queuing.
- op_a/op_b changes after the capture edge have no effect on the running operation.
- hi/lo:
  - Change only at completion; held otherwise, including across IDLE and later start captures.
  - The control unit asserts HILO_W during the done cycle.
- Counter is never compared with wrap-around; the RUN exit is count==WIDTH-1 at the step edge.

Optional Feature:
- Macro MULT_BOOTH_UNSIGNED_EN.
- Defined: adds input port is_unsigned (1 bit), sampled with start.
  - When is_unsigned=1, M and Q are zero-extended to WIDTH+1 bits, and Q carries an extra top bit.
  - RUN performs WIDTH+1 steps, so done arrives after edge N+WIDTH+1.
  - hi/lo take the low 2*WIDTH bits of the result.
  - When is_unsigned=0, behaviour and latency are identical to the signed path.
- Undefined: no is_unsigned port; all operations are signed with WIDTH steps.

Test Plan:
- Signed basic: reset release, then op_a=7, op_b=0xFFFFFFFD (-3), start=1 one cycle. Required: busy for 32 cycles; done pulse after edge N+32 with hi=0xFFFFFFFF, lo=0xFFFFFFEB; done low the next cycle.
- Extremes: op_a=op_b=0x80000000 gives hi=0x40000000, lo=0x00000000. op_a=op_b=0x7FFFFFFF gives hi=0x3FFFFFFF, lo=0x00000001. -1*-1 gives hi=0, lo=1.
- Handshake: pulse start again at step 10, and hold start high through DONE. Required: a single done at N+32 with result 7*-3. Re-capture only after returning to IDLE. Operand changes mid-RUN do not alter the result.
- Reset mid-operation: drive reset low at step 15. Required: busy=0, done=0, hi=lo=0 immediately (asynchronous). No done after release. Next 5*6 returns hi=0, lo=30.
- Hold: after a result, idle 20 cycles with operands changing. Required: hi/lo unchanged, done stays 0.
- With MULT_BOOTH_UNSIGNED_EN: 0xFFFFFFFF*0xFFFFFFFF with is_unsigned=1 gives hi=0xFFFFFFFE, lo=0x00000001 after 33 steps. With is_unsigned=0 it gives hi=0, lo=1 after 32 steps.
